lcd_frame_buffer: RTL and testbench

Double-buffered 128x64 monochrome frame store that sits directly upstream of the LCD panel driver. Game/render logic draws byte-wise into the draw bank while the driver reads the display bank. On request, the block swaps banks and issues the start pulse that launches one full panel refresh. It also guards the display bank for the length of that refresh.

---
 rtl/lcd_frame_buffer.sv | 150 +++++++++++++++
 tb/tb_lcd_frame_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_buffer.sv
// Double-buffered 128x64 monochrome frame store feeding the LCD panel driver.
// The draw side writes/clears one bank while the driver reads the other; a swap flips them and launches a refresh.
module lcd_frame_buffer #(
  parameter int START_HOLD  = 4,
  parameter int XFER_CYCLES = 2112
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic       wr_or_i,
  input  logic [9:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  input  logic       clr_i,
  input  logic       swap_i,
  output logic       busy_o,
  output logic       swap_pend_o,
  input  logic [9:0] addr_i,
  output logic [7:0] data_o,
  output logic       start_o,
  output logic [7:0] frame_cnt_o
);

  typedef enum logic [1:0] {D_INIT, D_IDLE, D_CLEAR} draw_state_t;
  typedef enum logic [1:0] {P_DIDLE, P_START, P_XFER} disp_state_t;

  localparam logic [15:0] HOLD_LAST = 16'(START_HOLD - 1);
  localparam logic [15:0] XFER_LAST = 16'(XFER_CYCLES - 1);

  logic [7:0]  bank0 [0:1023];
  logic [7:0]  bank1 [0:1023];

  draw_state_t draw_state;
  disp_state_t disp_state;
  logic [9:0]  fill_cnt;
  logic [15:0] hold_cnt;
  logic        disp_sel;
  logic        pend;

  logic        wr_fire;
  logic        fill_act;
  logic        draw_free;
  logic        disp_free;
  logic        swap_go;
  logic [7:0]  draw_rd;
  logic [7:0]  wr_byte;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        we0;
  logic        we1;

  always_comb begin
    wr_fire   = (draw_state == D_IDLE) && wr_en_i;
    fill_act  = (draw_state == D_INIT) || (draw_state == D_CLEAR);
    // The last clear cycle counts as free: its final byte still lands in the pre-swap draw bank.
    draw_free = (draw_state == D_IDLE) ||
                ((draw_state == D_CLEAR) && (fill_cnt == 10'd1023));
    disp_free = (disp_state == P_DIDLE) ||
                ((disp_state == P_XFER) && (hold_cnt == XFER_LAST));
    swap_go   = (pend || swap_i) && draw_free && disp_free;
    draw_rd   = disp_sel ? bank0[wr_addr_i] : bank1[wr_addr_i];
    wr_byte   = wr_or_i ? (draw_rd | wr_data_i) : wr_data_i;
    mem_addr  = fill_act ? fill_cnt : wr_addr_i;
    mem_data  = fill_act ? 8'h00 : wr_byte;
    we0 = !rst && ((draw_state == D_INIT) ||
                   ((draw_state == D_CLEAR || wr_fire) && disp_sel));
    we1 = !rst && ((draw_state == D_INIT) ||
                   ((draw_state == D_CLEAR || wr_fire) && !disp_sel));
  end

  assign data_o      = disp_sel ? bank1[addr_i] : bank0[addr_i];
  assign swap_pend_o = pend;

  always_ff @(posedge clk) begin
    if (we0) bank0[mem_addr] <= mem_data;
    if (we1) bank1[mem_addr] <= mem_data;
  end

  // Draw side: power-up wipe of both banks, byte writes, full draw-bank clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      draw_state <= D_INIT;
      fill_cnt   <= 10'd0;
      busy_o     <= 1'b1;
      wr_ready_o <= 1'b0;
    end else begin
      case (draw_state)
        D_IDLE: begin
          if (clr_i) begin
            draw_state <= D_CLEAR;
            fill_cnt   <= 10'd0;
            busy_o     <= 1'b1;
            wr_ready_o <= 1'b0;
          end
        end
        D_INIT, D_CLEAR: begin
          fill_cnt <= fill_cnt + 10'd1;
          if (fill_cnt == 10'd1023) begin
            draw_state <= D_IDLE;
            busy_o     <= 1'b0;
            wr_ready_o <= 1'b1;
          end
        end
        default: draw_state <= D_INIT;
      endcase
    end
  end

  // Display side: swap bookkeeping, start pulse, and refresh lockout.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_state  <= P_DIDLE;
      hold_cnt    <= 16'd0;
      start_o     <= 1'b0;
      disp_sel    <= 1'b0;
      frame_cnt_o <= 8'd0;
      pend        <= 1'b0;
    end else if (swap_go) begin
      disp_sel    <= ~disp_sel;
      frame_cnt_o <= frame_cnt_o + 8'd1;
      pend        <= 1'b0;
      disp_state  <= P_START;
      start_o     <= 1'b1;
      hold_cnt    <= 16'd0;
    end else begin
      if (swap_i) pend <= 1'b1;
      case (disp_state)
        P_START: begin
          if (hold_cnt == HOLD_LAST) begin
            disp_state <= P_XFER;
            start_o    <= 1'b0;
            hold_cnt   <= 16'd0;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        P_XFER: begin
          if (hold_cnt == XFER_LAST) begin
            disp_state <= P_DIDLE;
            hold_cnt   <= 16'd0;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: disp_state <= P_DIDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_buffer.sv
// Self-checking bench for lcd_frame_buffer: vector table for draw/OR writes, scoreboard for bank reads,
// hand sequences for refresh lockout, clear, and mid-operation reset.
module tb_lcd_frame_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en_i = 1'b0;
  logic       wr_or_i = 1'b0;
  logic [9:0] wr_addr_i = 10'd0;
  logic [7:0] wr_data_i = 8'd0;
  logic       wr_ready_o;
  logic       clr_i = 1'b0;
  logic       swap_i = 1'b0;
  logic       busy_o;
  logic       swap_pend_o;
  logic [9:0] addr_i = 10'd0;
  logic [7:0] data_o;
  logic       start_o;
  logic [7:0] frame_cnt_o;

  lcd_frame_buffer #(.START_HOLD(4), .XFER_CYCLES(2112)) dut (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en_i), .wr_or_i(wr_or_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .clr_i(clr_i), .swap_i(swap_i), .busy_o(busy_o),
    .swap_pend_o(swap_pend_o), .addr_i(addr_i), .data_o(data_o), .start_o(start_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mb0 [0:1023];
  logic [7:0] mb1 [0:1023];
  logic       m_sel;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] d1;
    logic       or2;
    logic [7:0] d2;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < 1024; i++) begin
      mb0[i] = 8'h00;
      mb1[i] = 8'h00;
    end
    m_sel = 1'b0;
  endtask

  task automatic model_clear_draw();
    for (int i = 0; i < 1024; i++) begin
      if (m_sel) mb0[i] = 8'h00;
      else mb1[i] = 8'h00;
    end
  endtask

  function automatic logic [7:0] model_disp(input logic [9:0] a);
    return m_sel ? mb1[a] : mb0[a];
  endfunction

  task automatic do_write(input logic [9:0] a, input logic [7:0] d, input logic or_en);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    wr_or_i   = or_en;
    if (m_sel) mb0[a] = or_en ? (mb0[a] | d) : d;
    else mb1[a] = or_en ? (mb1[a] | d) : d;
    tick();
    wr_en_i = 1'b0;
    wr_or_i = 1'b0;
  endtask

  task automatic read_push(input logic [9:0] a, input logic [7:0] e);
    logic [7:0] want;
    addr_i = a;
    exp_q.push_back(e);
    #1;
    want = exp_q.pop_front();
    check($sformatf("read_%0h", a), {24'd0, data_o}, {24'd0, want});
  endtask

  task automatic pulse_swap();
    swap_i = 1'b1;
    tick();
    swap_i = 1'b0;
  endtask

  task automatic wait_busy_low(input string name);
    int n = 0;
    while (busy_o && n < 1200) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic wait_frame(input string name, input logic [7:0] f);
    int n = 0;
    while (frame_cnt_o != f && n < 3000) begin
      tick();
      n++;
    end
    check(name, {24'd0, frame_cnt_o}, {24'd0, f});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int ready_early;
    int start_cycles;
    int k;
    int pend_drop;

    vecs[0] = '{addr: 10'h040, d1: 8'h81, or2: 1'b1, d2: 8'h18, exp: 8'h99};
    vecs[1] = '{addr: 10'h000, d1: 8'hF0, or2: 1'b1, d2: 8'h0F, exp: 8'hFF};
    vecs[2] = '{addr: 10'h3FF, d1: 8'hAA, or2: 1'b0, d2: 8'h55, exp: 8'h55};
    vecs[3] = '{addr: 10'h200, d1: 8'h01, or2: 1'b1, d2: 8'h01, exp: 8'h01};
    vecs[4] = '{addr: 10'h1C3, d1: 8'h00, or2: 1'b1, d2: 8'h80, exp: 8'h80};
    model_init();

    // Reset state and power-up wipe.
    repeat (3) tick();
    check("rst_busy", {31'd0, busy_o}, 32'd1);
    check("rst_ready", {31'd0, wr_ready_o}, 32'd0);
    check("rst_start", {31'd0, start_o}, 32'd0);
    check("rst_frame", {24'd0, frame_cnt_o}, 32'd0);
    check("rst_pend", {31'd0, swap_pend_o}, 32'd0);
    rst = 1'b0;
    busy_cycles = 0;
    ready_early = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (!busy_o) break;
      busy_cycles++;
      if (wr_ready_o) ready_early++;
    end
    check("init_busy_cycles", busy_cycles, 1024);
    check("init_ready_during_busy", ready_early, 0);
    check("init_ready_after", {31'd0, wr_ready_o}, 32'd1);
    tick();
    read_push(10'd0, 8'h00);
    read_push(10'd511, 8'h00);
    read_push(10'd1023, 8'h00);

    // Overwrite / OR vectors, back-to-back per address, then present them.
    for (int i = 0; i < 5; i++) begin
      do_write(vecs[i].addr, vecs[i].d1, 1'b0);
      do_write(vecs[i].addr, vecs[i].d2, vecs[i].or2);
    end
    pulse_swap();
    m_sel = ~m_sel;
    check("swap1_pend_never", {31'd0, swap_pend_o}, 32'd0);
    check("swap1_frame", {24'd0, frame_cnt_o}, 32'd1);
    start_cycles = 0;
    while (start_o && start_cycles < 20) begin
      start_cycles++;
      tick();
    end
    check("start_hold_cycles", start_cycles, 4);
    for (int i = 0; i < 5; i++) read_push(vecs[i].addr, vecs[i].exp);

    // Swap during XFER waits exactly XFER_CYCLES from the falling edge of start.
    k = 0;
    while (k < 3000 && frame_cnt_o != 8'd2) begin
      swap_i = (k == 10);
      if (k == 20) check("xfer_pend_set", {31'd0, swap_pend_o}, 32'd1);
      if (k == 2111) begin
        check("xfer_pend_last", {31'd0, swap_pend_o}, 32'd1);
        read_push(10'h040, 8'h99);
      end
      tick();
      k++;
    end
    swap_i = 1'b0;
    m_sel = ~m_sel;
    check("xfer_swap_edge", k, 2112);
    check("swap2_frame", {24'd0, frame_cnt_o}, 32'd2);
    check("swap2_pend_clr", {31'd0, swap_pend_o}, 32'd0);
    read_push(10'h040, model_disp(10'h040));

    // Fill, clear, swap queued behind the clear.
    repeat (2120) tick();
    for (int i = 0; i < 1024; i++) do_write(10'(i), 8'hFF, 1'b0);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    model_clear_draw();
    pulse_swap();
    check("clr_pend_set", {31'd0, swap_pend_o}, 32'd1);
    pend_drop = 0;
    k = 0;
    while (busy_o && k < 1100) begin
      if (!swap_pend_o) pend_drop++;
      tick();
      k++;
    end
    check("clr_done", {31'd0, busy_o}, 32'd0);
    check("clr_pend_held", pend_drop, 0);
    check("clr_swap_at_finish", {24'd0, frame_cnt_o}, 32'd3);
    m_sel = ~m_sel;
    for (int i = 0; i < 1024; i++) read_push(10'(i), model_disp(10'(i)));

    // Clear and write in the same IDLE cycle: the clear wins.
    clr_i     = 1'b1;
    wr_en_i   = 1'b1;
    wr_addr_i = 10'd5;
    wr_data_i = 8'h3C;
    tick();
    clr_i   = 1'b0;
    wr_en_i = 1'b0;
    model_clear_draw();
    check("clrwr_ready_drop", {31'd0, wr_ready_o}, 32'd0);
    check("clrwr_busy", {31'd0, busy_o}, 32'd1);
    wait_busy_low("clrwr_done");
    pulse_swap();
    check("clrwr_pend", {31'd0, swap_pend_o}, 32'd1);
    wait_frame("swap4_frame", 8'd4);
    m_sel = ~m_sel;
    read_push(10'd5, 8'h00);

    // Reset during START.
    check("pre_rst_start", {31'd0, start_o}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_init();
    check("rst_start_start", {31'd0, start_o}, 32'd0);
    check("rst_start_frame", {24'd0, frame_cnt_o}, 32'd0);
    check("rst_start_busy", {31'd0, busy_o}, 32'd1);
    check("rst_start_ready", {31'd0, wr_ready_o}, 32'd0);
    wait_busy_low("rst_start_init");

    // Reset during XFER.
    do_write(10'd7, 8'h5A, 1'b0);
    pulse_swap();
    m_sel = ~m_sel;
    check("post_rst_frame", {24'd0, frame_cnt_o}, 32'd1);
    read_push(10'd7, 8'h5A);
    k = 0;
    while (start_o && k < 10) begin
      tick();
      k++;
    end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_init();
    check("rst_xfer_start", {31'd0, start_o}, 32'd0);
    check("rst_xfer_frame", {24'd0, frame_cnt_o}, 32'd0);
    check("rst_xfer_busy", {31'd0, busy_o}, 32'd1);
    check("rst_xfer_pend", {31'd0, swap_pend_o}, 32'd0);
    wait_busy_low("rst_xfer_init");
    for (int i = 0; i < 1024; i++) read_push(10'(i), model_disp(10'(i)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
